// File: rtl/invaders_pkg.sv
// Shared geometry, coordinate widths and FSM encoding for the invaders playfield.
package invaders_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int ROW_W    = 9;
  localparam int COL_W    = 10;

  localparam int DEF_NUM_BULLETS = 4;
  localparam int DEF_NUM_ROWS    = 5;
  localparam int DEF_NUM_COLS    = 10;
  localparam int DEF_ALIEN_W     = 30;
  localparam int DEF_ALIEN_H     = 20;
  localparam int DEF_GAP_W       = 10;
  localparam int DEF_GAP_H       = 10;
  localparam int DEF_STEP        = 10;
  localparam int DEF_MUZZLE_OFF  = 15;
  localparam int DEF_COOLDOWN    = 3;
  localparam int OFFSCREEN       = 500;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

endpackage

// File: rtl/bullet_hit_calc.sv
// Maps one bullet position onto the alien formation: reports whether the
// point lies inside an alien sprite cell (not a gap) and which grid index.
module bullet_hit_calc
  import invaders_pkg::*;
#(
  parameter int NUM_ROWS = DEF_NUM_ROWS,
  parameter int NUM_COLS = DEF_NUM_COLS,
  parameter int ALIEN_W  = DEF_ALIEN_W,
  parameter int ALIEN_H  = DEF_ALIEN_H,
  parameter int GAP_W    = DEF_GAP_W,
  parameter int GAP_H    = DEF_GAP_H,
  parameter int IDX_W    = 6
) (
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  input  logic [ROW_W-1:0] origin_row,
  input  logic [COL_W-1:0] origin_col,
  output logic             in_cell,
  output logic [IDX_W-1:0] grid_index
);

  localparam int PITCH_W = ALIEN_W + GAP_W;
  localparam int PITCH_H = ALIEN_H + GAP_H;

  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic [9:0] cell_c;
  logic [9:0] cell_r;
  logic [9:0] off_x;
  logic [9:0] off_y;

  // Offset from the formation origin, split into cell number and offset within the cell.
  always_comb begin
    dx = signed'({1'b0, col}) - signed'({1'b0, origin_col});
    dy = signed'({2'b00, row}) - signed'({2'b00, origin_row});
    cell_c = dx[9:0] / 10'(PITCH_W);
    off_x  = dx[9:0] % 10'(PITCH_W);
    cell_r = dy[9:0] / 10'(PITCH_H);
    off_y  = dy[9:0] % 10'(PITCH_H);
    // Negative offsets lie above/left of the formation and can never hit.
    in_cell = !dx[10] && !dy[10] &&
              (cell_c < 10'(NUM_COLS)) && (cell_r < 10'(NUM_ROWS)) &&
              (off_x < 10'(ALIEN_W)) && (off_y < 10'(ALIEN_H));
    grid_index = IDX_W'(32'(cell_r) * NUM_COLS + 32'(cell_c));
  end

endmodule

// File: rtl/bullet_pool.sv
// Multi-shot player bullet pool plus the alien-alive grid. Each Tick spawns
// at most one shot, moves all live bullets up, then checks one slot per clock.
module bullet_pool
  import invaders_pkg::*;
#(
  parameter int NUM_BULLETS = DEF_NUM_BULLETS,
  parameter int NUM_ROWS    = DEF_NUM_ROWS,
  parameter int NUM_COLS    = DEF_NUM_COLS,
  parameter int ALIEN_W     = DEF_ALIEN_W,
  parameter int ALIEN_H     = DEF_ALIEN_H,
  parameter int GAP_W       = DEF_GAP_W,
  parameter int GAP_H       = DEF_GAP_H,
  parameter int STEP        = DEF_STEP,
  parameter int MUZZLE_OFF  = DEF_MUZZLE_OFF,
  parameter int COOLDOWN    = DEF_COOLDOWN
) (
  input  logic                                Clk,
  input  logic                                Reset,
  input  logic                                Tick,
  input  logic                                Wave_Reset,
  input  logic                                Bullet_Fired,
  input  logic [8:0]                          Aliens_Row,
  input  logic [9:0]                          Aliens_Col,
  input  logic [8:0]                          Player_Row,
  input  logic [9:0]                          Player_Col,
  output logic [9*NUM_BULLETS-1:0]            Bullet_Row,
  output logic [10*NUM_BULLETS-1:0]           Bullet_Col,
  output logic [NUM_BULLETS-1:0]              Bullet_Active,
  output logic [NUM_ROWS*NUM_COLS-1:0]        Aliens_Grid,
  output logic                                Aliens_Defeated,
  output logic                                Hit_Pulse,
  output logic [$clog2(NUM_ROWS*NUM_COLS)-1:0] Hit_Index,
  output logic                                Busy
);

  localparam int IDX_W = $clog2(NUM_ROWS * NUM_COLS);
  localparam int KW    = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  state_t                        state;
  logic                          busy;
  logic [KW-1:0]                 k_q;
  logic [CD_W-1:0]               cd_q;
  logic                          fire_pend;
  logic [NUM_BULLETS-1:0]        active_q;
  logic [ROW_W-1:0]              row_q [NUM_BULLETS];
  logic [COL_W-1:0]              col_q [NUM_BULLETS];
  logic [NUM_ROWS*NUM_COLS-1:0]  grid_q;
  logic                          hit_pulse;
  logic [IDX_W-1:0]              hit_index;

  logic                          free_found;
  logic [KW-1:0]                 free_slot;
  logic                          cell_hit;
  logic [IDX_W-1:0]              hit_idx;
  logic                          hit;

  // Spawn column: muzzle offset added to the player column, clamped to the coordinate range.
  function automatic logic [COL_W-1:0] sat_col(input logic [COL_W-1:0] base);
    logic [COL_W:0] sum;
    sum = {1'b0, base} + (COL_W+1)'(MUZZLE_OFF);
    return sum[COL_W] ? {COL_W{1'b1}} : sum[COL_W-1:0];
  endfunction

  // Lowest-numbered inactive slot, judged on state before this cycle's moves.
  always_comb begin
    free_found = 1'b0;
    free_slot  = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_slot  = KW'(i);
      end
    end
  end

  bullet_hit_calc #(
    .NUM_ROWS (NUM_ROWS),
    .NUM_COLS (NUM_COLS),
    .ALIEN_W  (ALIEN_W),
    .ALIEN_H  (ALIEN_H),
    .GAP_W    (GAP_W),
    .GAP_H    (GAP_H),
    .IDX_W    (IDX_W)
  ) u_hit_calc (
    .row        (row_q[k_q]),
    .col        (col_q[k_q]),
    .origin_row (Aliens_Row),
    .origin_col (Aliens_Col),
    .in_cell    (cell_hit),
    .grid_index (hit_idx)
  );

  // A kill needs a live bullet, an alien cell and a still-alive alien there.
  always_comb begin
    hit = (state == ST_CHECK) && active_q[k_q] && cell_hit && grid_q[hit_idx];
  end

  // Frame FSM: IDLE -> MOVE (spawn + rise) -> CHECK (one slot per clock) -> IDLE.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      k_q       <= '0;
      cd_q      <= '0;
      fire_pend <= 1'b0;
      active_q  <= '0;
      grid_q    <= '1;
      hit_pulse <= 1'b0;
      hit_index <= '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        row_q[i] <= ROW_W'(OFFSCREEN);
        col_q[i] <= '0;
      end
    end else if (Wave_Reset) begin
      // New wave: everything back to power-up state except the last kill index.
      state     <= ST_IDLE;
      busy      <= 1'b0;
      k_q       <= '0;
      cd_q      <= '0;
      fire_pend <= 1'b0;
      active_q  <= '0;
      grid_q    <= '1;
      hit_pulse <= 1'b0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        row_q[i] <= ROW_W'(OFFSCREEN);
        col_q[i] <= '0;
      end
    end else begin
      hit_pulse <= 1'b0;
      if (Bullet_Fired) fire_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (Tick) begin
            state <= ST_MOVE;
            busy  <= 1'b1;
          end
        end
        ST_MOVE: begin
          for (int i = 0; i < NUM_BULLETS; i++) begin
            if (active_q[i]) begin
              if (row_q[i] < ROW_W'(STEP)) begin
                active_q[i] <= 1'b0;
                row_q[i]    <= ROW_W'(OFFSCREEN);
              end else begin
                row_q[i] <= row_q[i] - ROW_W'(STEP);
              end
            end
          end
          // The spawned slot was free, so the move loop above never touched it.
          if (fire_pend && (cd_q == '0) && free_found) begin
            row_q[free_slot]    <= Player_Row;
            col_q[free_slot]    <= sat_col(Player_Col);
            active_q[free_slot] <= 1'b1;
            cd_q                <= CD_W'(COOLDOWN);
          end else if (cd_q != '0) begin
            cd_q <= cd_q - CD_W'(1);
          end
          // Pending request is consumed here; a press landing in this very cycle still counts.
          fire_pend <= Bullet_Fired;
          k_q       <= '0;
          state     <= ST_CHECK;
        end
        ST_CHECK: begin
          if (hit) begin
            grid_q[hit_idx] <= 1'b0;
            active_q[k_q]   <= 1'b0;
            row_q[k_q]      <= ROW_W'(OFFSCREEN);
            hit_pulse       <= 1'b1;
            hit_index       <= hit_idx;
          end
          if (k_q == KW'(NUM_BULLETS - 1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_pack
    assign Bullet_Row[9*g +: 9]   = row_q[g];
    assign Bullet_Col[10*g +: 10] = col_q[g];
  end

  assign Bullet_Active   = active_q;
  assign Aliens_Grid     = grid_q;
  assign Aliens_Defeated = (grid_q == '0);
  assign Hit_Pulse       = hit_pulse;
  assign Hit_Index       = hit_index;
  assign Busy            = busy;

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool with hand-computed expectations.
module tb_bullet_pool;

  localparam logic [49:0] FULL = {50{1'b1}};

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Tick;
  logic        Wave_Reset;
  logic        Bullet_Fired;
  logic [8:0]  Aliens_Row;
  logic [9:0]  Aliens_Col;
  logic [8:0]  Player_Row;
  logic [9:0]  Player_Col;
  logic [35:0] Bullet_Row;
  logic [39:0] Bullet_Col;
  logic [3:0]  Bullet_Active;
  logic [49:0] Aliens_Grid;
  logic        Aliens_Defeated;
  logic        Hit_Pulse;
  logic [5:0]  Hit_Index;
  logic        Busy;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;
  int p0;

  bullet_pool dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .Tick            (Tick),
    .Wave_Reset      (Wave_Reset),
    .Bullet_Fired    (Bullet_Fired),
    .Aliens_Row      (Aliens_Row),
    .Aliens_Col      (Aliens_Col),
    .Player_Row      (Player_Row),
    .Player_Col      (Player_Col),
    .Bullet_Row      (Bullet_Row),
    .Bullet_Col      (Bullet_Col),
    .Bullet_Active   (Bullet_Active),
    .Aliens_Grid     (Aliens_Grid),
    .Aliens_Defeated (Aliens_Defeated),
    .Hit_Pulse       (Hit_Pulse),
    .Hit_Index       (Hit_Index),
    .Busy            (Busy)
  );

  always #5 Clk = ~Clk;

  // Count every cycle Hit_Pulse is high.
  always @(negedge Clk) if (Hit_Pulse) pulse_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] brow(input int k);
    return Bullet_Row[9*k +: 9];
  endfunction

  function automatic logic [9:0] bcol(input int k);
    return Bullet_Col[10*k +: 10];
  endfunction

  task automatic fire();
    @(negedge Clk); Bullet_Fired = 1'b1;
    @(negedge Clk); Bullet_Fired = 1'b0;
  endtask

  task automatic wave_reset();
    @(negedge Clk); Wave_Reset = 1'b1;
    @(negedge Clk); Wave_Reset = 1'b0;
  endtask

  task automatic do_tick();
    int n;
    @(negedge Clk); Tick = 1'b1;
    @(negedge Clk); Tick = 1'b0;
    n = 0;
    while (Busy && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk("tick_done", 64'(Busy), 64'(0));
    @(negedge Clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1; Tick = 1'b0; Wave_Reset = 1'b0; Bullet_Fired = 1'b0;
    Aliens_Row = 9'd50; Aliens_Col = 10'd600;
    Player_Row = 9'd400; Player_Col = 10'd100;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;

    // Reset state
    chk("rst_active", 64'(Bullet_Active), 64'(0));
    chk("rst_rows", 64'(Bullet_Row), 64'({4{9'd500}}));
    chk("rst_cols", 64'(Bullet_Col), 64'(0));
    chk("rst_grid", 64'(Aliens_Grid), 64'(FULL));
    chk("rst_pulse", 64'(Hit_Pulse), 64'(0));
    chk("rst_index", 64'(Hit_Index), 64'(0));
    chk("rst_busy", 64'(Busy), 64'(0));
    chk("rst_defeated", 64'(Aliens_Defeated), 64'(0));

    // Idle ticks with no fire
    repeat (5) do_tick();
    chk("idle_active", 64'(Bullet_Active), 64'(0));
    chk("idle_rows", 64'(Bullet_Row), 64'({4{9'd500}}));
    chk("idle_grid", 64'(Aliens_Grid), 64'(FULL));
    chk("idle_pulses", 64'(pulse_cnt), 64'(0));

    // Spawn and rise to the top edge
    fire();
    do_tick();
    chk("spawn_row", 64'(brow(0)), 64'(400));
    chk("spawn_col", 64'(bcol(0)), 64'(115));
    chk("spawn_active", 64'(Bullet_Active), 64'(4'b0001));
    do_tick();
    chk("rise_row", 64'(brow(0)), 64'(390));
    repeat (39) do_tick();
    chk("top_row", 64'(brow(0)), 64'(0));
    chk("top_active", 64'(Bullet_Active), 64'(4'b0001));
    do_tick();
    chk("off_active", 64'(Bullet_Active), 64'(0));
    chk("off_row", 64'(brow(0)), 64'(500));

    // Fire held continuously: cooldown spaces spawns 4 Ticks apart
    wave_reset();
    Bullet_Fired = 1'b1;
    for (int t = 1; t <= 17; t++) begin
      do_tick();
      chk("held_active", 64'(Bullet_Active),
          64'((t >= 13) ? 4'b1111 : (t >= 9) ? 4'b0111 : (t >= 5) ? 4'b0011 : 4'b0001));
    end
    Bullet_Fired = 1'b0;
    chk("held_row0", 64'(brow(0)), 64'(240));
    chk("held_row1", 64'(brow(1)), 64'(280));
    chk("held_row3", 64'(brow(3)), 64'(360));

    // Spawn column saturation
    wave_reset();
    Player_Col = 10'd1015;
    fire();
    do_tick();
    chk("sat_col", 64'(bcol(0)), 64'(1023));

    // Two bullets in the same alien cell
    wave_reset();
    Aliens_Row = 9'd240; Aliens_Col = 10'd600;
    Player_Row = 9'd300; Player_Col = 10'd100;
    fire();
    do_tick();
    repeat (3) do_tick();
    Player_Row = 9'd260;
    fire();
    do_tick();
    chk("pair_active", 64'(Bullet_Active), 64'(4'b0011));
    chk("pair_row0", 64'(brow(0)), 64'(260));
    chk("pair_row1", 64'(brow(1)), 64'(260));
    Aliens_Col = 10'd100;
    p0 = pulse_cnt;
    do_tick();
    chk("pair_grid", 64'(Aliens_Grid), 64'(FULL & ~50'd1));
    chk("pair_active2", 64'(Bullet_Active), 64'(4'b0010));
    chk("pair_row0_off", 64'(brow(0)), 64'(500));
    chk("pair_row1_live", 64'(brow(1)), 64'(250));
    chk("pair_index", 64'(Hit_Index), 64'(0));
    chk("pair_pulses", 64'(pulse_cnt - p0), 64'(1));
    do_tick();
    chk("pair_follow_active", 64'(Bullet_Active), 64'(4'b0010));
    chk("pair_follow_row", 64'(brow(1)), 64'(240));
    chk("pair_follow_pulses", 64'(pulse_cnt - p0), 64'(1));

    // Single hit at origin (50,100)
    wave_reset();
    Aliens_Row = 9'd50; Aliens_Col = 10'd100;
    Player_Row = 9'd75; Player_Col = 10'd130;
    fire();
    do_tick();
    chk("hit_spawn_row", 64'(brow(0)), 64'(75));
    chk("hit_spawn_col", 64'(bcol(0)), 64'(145));
    chk("hit_spawn_grid", 64'(Aliens_Grid), 64'(FULL));
    p0 = pulse_cnt;
    do_tick();
    chk("hit_grid", 64'(Aliens_Grid), 64'(FULL & ~50'd2));
    chk("hit_index", 64'(Hit_Index), 64'(1));
    chk("hit_pulses", 64'(pulse_cnt - p0), 64'(1));
    chk("hit_active", 64'(Bullet_Active), 64'(0));
    chk("hit_row", 64'(brow(0)), 64'(500));

    // Wave_Reset while the FSM is in CHECK
    Aliens_Col = 10'd600;
    repeat (2) do_tick();
    fire();
    @(negedge Clk); Tick = 1'b1;
    @(negedge Clk); Tick = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("mid_busy", 64'(Busy), 64'(1));
    chk("mid_active", 64'(Bullet_Active), 64'(4'b0001));
    Wave_Reset = 1'b1;
    @(negedge Clk); Wave_Reset = 1'b0;
    chk("wr_busy", 64'(Busy), 64'(0));
    chk("wr_active", 64'(Bullet_Active), 64'(0));
    chk("wr_grid", 64'(Aliens_Grid), 64'(FULL));
    chk("wr_rows", 64'(Bullet_Row), 64'({4{9'd500}}));
    chk("wr_index_hold", 64'(Hit_Index), 64'(1));

    // Bullet in the horizontal gap between aliens
    wave_reset();
    Aliens_Row = 9'd50; Aliens_Col = 10'd100;
    Player_Row = 9'd60; Player_Col = 10'd117;
    fire();
    do_tick();
    chk("gap_col", 64'(bcol(0)), 64'(132));
    chk("gap_grid1", 64'(Aliens_Grid), 64'(FULL));
    do_tick();
    chk("gap_row", 64'(brow(0)), 64'(50));
    chk("gap_grid2", 64'(Aliens_Grid), 64'(FULL));
    chk("gap_active", 64'(Bullet_Active), 64'(4'b0001));

    // Clear every alien, one spawn-tick kill at a time
    wave_reset();
    Player_Row = 9'd300; Player_Col = 10'd485;
    p0 = pulse_cnt;
    for (int idx = 0; idx < 50; idx++) begin
      Aliens_Row = 9'(295 - 30 * (idx / 10));
      Aliens_Col = 10'(495 - 40 * (idx % 10));
      chk("clr_defeated_before", 64'(Aliens_Defeated), 64'(0));
      fire();
      do_tick();
      chk("clr_index", 64'(Hit_Index), 64'(idx));
      chk("clr_active", 64'(Bullet_Active), 64'(0));
      repeat (3) do_tick();
    end
    chk("clr_grid", 64'(Aliens_Grid), 64'(0));
    chk("clr_defeated", 64'(Aliens_Defeated), 64'(1));
    chk("clr_pulses", 64'(pulse_cnt - p0), 64'(50));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
